// File: rtl/cnn_load_sched.sv
// cnn_load_sched: loads the packed fmap/weight/bias operand vector tile by tile into the
// operand combiner, starts the CNN core, and waits for it before moving to the next tile.
// Optional watchdog: define CNN_LOAD_SCHED_TMO_EN to enable the stall timeout and err output.
module cnn_load_sched #(
  parameter int unsigned NUM_WORDS = 40,
  parameter int unsigned ADDR_BW   = 32,
  parameter int unsigned TILE_BW   = 16,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned OUT_DLY   = 2,
  parameter int unsigned TMO_CYC   = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [TILE_BW-1:0] num_tiles,
  input  logic [ADDR_BW-1:0] base_addr,
  output logic               busy,
  output logic               tile_done,
  output logic               all_done,
  output logic               rd_req,
  output logic [ADDR_BW-1:0] rd_addr,
  input  logic               rd_ack,
  input  logic [31:0]        rd_data,
  output logic [31:0]        f_data,
  output logic [31:0]        f_address,
  output logic               f_enable,
  output logic               f_value_done,
  output logic               f_done,
  output logic               core_start,
  input  logic               core_done,
  output logic               err
);

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CntW = 16;
  localparam logic [IdxW-1:0]    LastIdx   = IdxW'(NUM_WORDS - 1);
  localparam logic [ADDR_BW-1:0] TileStep  = ADDR_BW'(NUM_WORDS);
  localparam logic [CntW-1:0]    DrainLast = CntW'(DRAIN_CYC - 1);
  localparam logic [CntW-1:0]    DlyLast   = CntW'(OUT_DLY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StLock,
    StDoneHold,
    StWait
  } state_e;

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic [TILE_BW-1:0] tile_q;
  logic [TILE_BW-1:0] num_tiles_q;
  logic [ADDR_BW-1:0] tile_base_q;
  logic [CntW-1:0]    cnt_q;
  logic               core_done_ok;
  logic               tmo_hit;

  // A core_done coinciding with our own start pulse belongs to an earlier run, not this tile.
  assign core_done_ok = core_done && !core_start;

`ifdef CNN_LOAD_SCHED_TMO_EN
  localparam int unsigned WdW = $clog2(TMO_CYC + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TMO_CYC - 1);

  logic [WdW-1:0] wd_q;
  logic           err_q;
  logic           wd_idle;

  assign wd_idle = ((state_q == StFetch) && !rd_ack) || ((state_q == StWait) && !core_done_ok);
  assign tmo_hit = wd_idle && (wd_q == WdLast);
  assign err     = err_q;

  // Watchdog: counts consecutive cycles stuck waiting on the read port or the core.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      wd_q  <= '0;
      err_q <= 1'b1;
    end else if (wd_idle) begin
      wd_q  <= wd_q + WdW'(1);
    end else begin
      wd_q  <= '0;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^32'(TMO_CYC);
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  // Main sequencer: state, counters and all registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tile_q       <= '0;
      num_tiles_q  <= '0;
      tile_base_q  <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      tile_done    <= 1'b0;
      all_done     <= 1'b0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      f_data       <= '0;
      f_address    <= '0;
      f_enable     <= 1'b0;
      f_value_done <= 1'b0;
      f_done       <= 1'b0;
      core_start   <= 1'b0;
    end else begin
      tile_done  <= 1'b0;
      all_done   <= 1'b0;
      core_start <= 1'b0;
      if (tmo_hit) begin
        // Abort the job; keep the combiner write-locked while idle.
        state_q      <= StIdle;
        busy         <= 1'b0;
        rd_req       <= 1'b0;
        f_enable     <= 1'b0;
        f_done       <= 1'b0;
        f_value_done <= 1'b1;
        all_done     <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (num_tiles == '0) begin
                all_done <= 1'b1;
              end else begin
                state_q      <= StFetch;
                busy         <= 1'b1;
                rd_req       <= 1'b1;
                f_enable     <= 1'b1;
                f_value_done <= 1'b0;
                num_tiles_q  <= num_tiles;
                tile_q       <= '0;
                idx_q        <= '0;
                tile_base_q  <= base_addr;
                rd_addr      <= base_addr;
              end
            end
          end
          StFetch: begin
            if (rd_ack) begin
              f_data    <= rd_data;
              f_address <= 32'(idx_q);
              rd_addr   <= rd_addr + ADDR_BW'(1);
              if (idx_q == LastIdx) begin
                rd_req  <= 1'b0;
                idx_q   <= '0;
                cnt_q   <= '0;
                state_q <= StDrain;
              end else begin
                idx_q   <= idx_q + IdxW'(1);
              end
            end
          end
          StDrain: begin
            // Keep the load window open while the combiner pipeline flushes.
            if (cnt_q == DrainLast) begin
              f_enable     <= 1'b0;
              f_value_done <= 1'b1;
              state_q      <= StLock;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StLock: begin
            f_value_done <= 1'b0;
            f_done       <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StDoneHold;
          end
          StDoneHold: begin
            // Wait for the combiner output registers before starting the core.
            if (cnt_q == DlyLast) begin
              core_start   <= 1'b1;
              f_value_done <= 1'b1;
              state_q      <= StWait;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StWait: begin
            if (core_done_ok) begin
              tile_done <= 1'b1;
              f_done    <= 1'b0;
              if (tile_q == num_tiles_q - TILE_BW'(1)) begin
                all_done <= 1'b1;
                busy     <= 1'b0;
                state_q  <= StIdle;
              end else begin
                // Tile base advances by accumulation rather than tile*NUM_WORDS.
                tile_q       <= tile_q + TILE_BW'(1);
                tile_base_q  <= tile_base_q + TileStep;
                rd_addr      <= tile_base_q + TileStep;
                idx_q        <= '0;
                rd_req       <= 1'b1;
                f_enable     <= 1'b1;
                f_value_done <= 1'b0;
                state_q      <= StFetch;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_load_sched.sv
// Scoreboard bench for cnn_load_sched with NUM_WORDS=4, DRAIN_CYC=4, OUT_DLY=2.
module tb_cnn_load_sched;

  localparam int NW    = 4;
  localparam int DRAIN = 4;
  localparam int DLY   = 2;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] num_tiles;
  logic [31:0] base_addr;
  logic        busy, tile_done, all_done, rd_req, rd_ack;
  logic [31:0] rd_addr, rd_data, f_data, f_address;
  logic        f_enable, f_value_done, f_done, core_start, core_done, err;

  cnn_load_sched #(
    .NUM_WORDS(NW),
    .ADDR_BW  (32),
    .TILE_BW  (16),
    .DRAIN_CYC(DRAIN),
    .OUT_DLY  (DLY),
    .TMO_CYC  (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .num_tiles   (num_tiles),
    .base_addr   (base_addr),
    .busy        (busy),
    .tile_done   (tile_done),
    .all_done    (all_done),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .f_data      (f_data),
    .f_address   (f_address),
    .f_enable    (f_enable),
    .f_value_done(f_value_done),
    .f_done      (f_done),
    .core_start  (core_start),
    .core_done   (core_done),
    .err         (err)
  );

  typedef struct {
    logic [31:0] addr;
    int          idx;
  } rd_exp_t;

  typedef struct {
    logic tile;
    logic all;
    int   cyc;
  } ev_exp_t;

  rd_exp_t rd_q[$];
  ev_exp_t ev_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Responder knobs
  int stall   = 0;
  bit stray   = 0;
  bit early   = 0;
  bit core_en = 1;
  int core_lat = 3;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-port responder: acks after `stall` idle cycles, optionally acks with no request.
  initial begin : rd_resp
    int wcnt;
    wcnt    = 0;
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_ack = 1'b0;
      if (rd_req) begin
        if (wcnt >= stall) begin
          rd_ack  = 1'b1;
          rd_data = dfn(rd_addr);
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (stray) begin
          rd_ack  = 1'b1;
          rd_data = 32'hBAD0_BAD0;
        end
      end
    end
  end

  // Core model: optional stray done coincident with start, real done after core_lat cycles.
  initial begin : core_resp
    core_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (core_start && reset_n) begin
        if (early) core_done = 1'b1;
        if (core_en) begin
          repeat (core_lat) begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
          end
          core_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents reads or completion pulses.
  logic [31:0] exp_fa, exp_fd;
  ev_exp_t     mon_ev;
  int          drain_cnt, vd_cnt, dly_cnt;
  bit          dly_arm, prev_en, prev_done;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_fa = '0; exp_fd = '0;
      drain_cnt = 0; vd_cnt = 0; dly_cnt = 0;
      dly_arm = 0; prev_en = 0; prev_done = 0;
    end else begin
      check("f_address", f_address, exp_fa);
      check("f_data", f_data, exp_fd);
      if (rd_req) begin
        if (rd_q.size() == 0) begin
          check("rd_req_unexpected", rd_req, 0);
        end else begin
          check("rd_addr", rd_addr, rd_q[0].addr);
          if (rd_ack) begin
            exp_fa = rd_q[0].idx;
            exp_fd = dfn(rd_q[0].addr);
            void'(rd_q.pop_front());
          end
        end
      end
      if (tile_done || all_done) begin
        if (ev_q.size() == 0) begin
          check("event_unexpected", {tile_done, all_done}, 0);
        end else begin
          mon_ev = ev_q.pop_front();
          check("tile_done", tile_done, mon_ev.tile);
          check("all_done", all_done, mon_ev.all);
          if (mon_ev.cyc > 0) check("all_done_latency", cyc, mon_ev.cyc);
        end
      end
      if (f_enable && !rd_req) drain_cnt++;
      if (prev_en && !f_enable) begin
        check("drain_cycles", drain_cnt, DRAIN);
        drain_cnt = 0;
      end
      if (f_value_done && !f_done && !f_enable && busy) vd_cnt++;
      if (f_done && !prev_done) begin
        check("lock_cycles", vd_cnt, 1);
        vd_cnt  = 0;
        dly_arm = 1;
        dly_cnt = 0;
      end
      if (dly_arm && f_done && !core_start) dly_cnt++;
      if (core_start) begin
        check("start_delay", dly_cnt, DLY);
        check("f_done_at_start", f_done, 1);
        dly_arm = 0;
      end
      prev_en   = f_enable;
      prev_done = f_done;
    end
  end

  task automatic run_job(input logic [31:0] base, input int tiles, input int st,
                         input bit early_i, input bit stray_i, input bit mid);
    ev_exp_t e;
    bit      done;
    stall   = st;
    early   = early_i;
    stray   = stray_i;
    core_en = 1;
    for (int t = 0; t < tiles; t++) begin
      for (int w = 0; w < NW; w++) rd_q.push_back('{addr: base + 32'(t * NW + w), idx: w});
      e = '{tile: 1'b1, all: (t == tiles - 1), cyc: 0};
      ev_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (tiles == 0) begin
      e = '{tile: 1'b0, all: 1'b1, cyc: cyc + 1};
      ev_q.push_back(e);
    end
    start     = 1'b1;
    num_tiles = 16'(tiles);
    base_addr = base;
    @(posedge clk);
    #1;
    start     = 1'b0;
    num_tiles = 16'hFFFF;
    base_addr = 32'hCAFE_0000;
    check("start_to_rd_req", rd_req, (tiles > 0));
    if (mid) begin
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      start     = 1'b1;
      num_tiles = 16'd7;
      base_addr = 32'hDEAD_0000;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (!busy && ev_q.size() == 0 && rd_q.size() == 0) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("job_complete", done, 1);
    rd_q.delete();
    ev_q.delete();
    stray = 0;
    early = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("busy_idle", busy, 0);
    if (tiles > 0) check("value_done_idle", f_value_done, 1);
  endtask

  initial begin : stim
    bit seen;
    reset_n   = 1'b1;
    start     = 1'b0;
    num_tiles = '0;
    base_addr = '0;
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl",
          {busy, tile_done, all_done, rd_req, f_enable, f_value_done, f_done, core_start, err}, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_f_data", f_data, 0);
    check("reset_f_address", f_address, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_job(32'h0000_0100, 1, 0, 0, 0, 0);   // single tile, ack every cycle
    run_job(32'h0000_0010, 3, 0, 1, 0, 0);   // three tiles, stray core_done with core_start
    run_job(32'h0000_0200, 1, 5, 0, 1, 1);   // 5-cycle stalls, stray acks, start mid-FETCH
    run_job(32'hFFFF_FFFE, 1, 0, 0, 0, 0);   // address wrap
    run_job(32'h0000_0400, 0, 0, 0, 0, 0);   // zero tiles

    // Reset while waiting on the core
    for (int w = 0; w < NW; w++) rd_q.push_back('{addr: 32'h300 + 32'(w), idx: w});
    core_en = 0;
    @(posedge clk);
    #1;
    start     = 1'b1;
    num_tiles = 16'd1;
    base_addr = 32'h300;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (core_start) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("reached_wait", seen, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("abort_ctrl",
          {busy, tile_done, all_done, rd_req, f_enable, f_value_done, f_done, core_start, err}, 0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_f_data", f_data, 0);
    check("abort_f_address", f_address, 0);
    rd_q.delete();
    ev_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    core_en = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("post_abort_busy", busy, 0);
    check("post_abort_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
